ddr5_dfi_command_encoder: RTL and testbench

- Controller-side command sequencer that drives the DFI command/address interface consumed by ddr5_phy_command_address.
- Accepts one abstract command per valid/ready handshake: WRITE or MODE REGISTER WRITE (MRW).
- Serialises each command into the DDR5 two-cycle form, UI0 then UI1, on dfi_address and dfi_cs_n.
- Enforces a programmable minimum deselect gap between consecutive commands.

---
 rtl/ddr5_phy_pkg.sv | 52 +++++
 rtl/ddr5_ca_pack.sv | 56 +++++
 rtl/ddr5_dfi_command_encoder.sv | 160 ++++++++++++++++
 tb/tb_ddr5_dfi_command_encoder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr5_phy_pkg.sv
// ----------------------------------------------------------------------------
// ddr5_phy_pkg
//   Shared DDR5 command/address definitions used by the controller-side
//   command encoder and by ddr5_phy_command_address on the PHY side.
//   Contents: abstract command type, encoder state type, 5-bit CA opcodes,
//   mode register addresses and the captured-command payload record.
// ----------------------------------------------------------------------------
package ddr5_phy_pkg;

    typedef enum logic [1:0] {
        NOP  = 2'b00,
        WR   = 2'b01,
        MRW  = 2'b10,
        RSVD = 2'b11
    } cmd_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CMD  = 2'b01,
        UI1  = 2'b10,
        GAP  = 2'b11
    } enc_state_e;

    // CA[4:0] opcodes for UI0
    localparam logic [4:0] CA_OP_WR  = 5'b01101;
    localparam logic [4:0] CA_OP_MRW = 5'b00101;

    // Mode register addresses understood by the PHY-side receiver
    localparam logic [7:0] MR_BL      = 8'h00;
    localparam logic [7:0] MR_PREPOST = 8'h08;
    localparam logic [7:0] MR_CRC     = 8'h32;

    localparam int unsigned CA_W = 14;

    // Command payload as captured at the handshake
    typedef struct packed {
        cmd_type_e  typ;
        logic [1:0] bank;
        logic [2:0] bg;
        logic [8:0] col;
        logic       ap;
        logic       bl_alt;
        logic [7:0] ma;
        logic [7:0] op;
        logic       cw;
    } cmd_fields_t;

    function automatic logic is_legal_type(input cmd_type_e t);
        return (t == WR) || (t == MRW);
    endfunction

endpackage

// File: rtl/ddr5_ca_pack.sv
// ----------------------------------------------------------------------------
// ddr5_ca_pack
//   Purely combinational mapping of one command payload to the 14-bit DDR5
//   CA word for either unit interval.
//   Ports:
//     cmd_type        command type (01 = WRITE, 10 = MRW, others give 0)
//     bank/bg/col     WRITE bank, bank group, column C[10:2]
//     ap/bl_alt       WRITE auto-precharge and alternate burst length
//     ma/op/cw        MRW address, opcode, control-word bit
//     ui_sel          0 = UI0 word, 1 = UI1 word
//     ca              packed CA word, unlisted bits zero
// ----------------------------------------------------------------------------
module ddr5_ca_pack
    import ddr5_phy_pkg::*;
(
    input  logic [1:0]      cmd_type,
    input  logic [1:0]      bank,
    input  logic [2:0]      bg,
    input  logic [8:0]      col,
    input  logic            ap,
    input  logic            bl_alt,
    input  logic [7:0]      ma,
    input  logic [7:0]      op,
    input  logic            cw,
    input  logic            ui_sel,
    output logic [CA_W-1:0] ca
);

    always_comb begin
        ca = '0;
        case (cmd_type)
            WR: begin
                if (!ui_sel) begin
                    ca[4:0]  = CA_OP_WR;
                    ca[5]    = ~bl_alt;
                    ca[7:6]  = bank;
                    ca[10:8] = bg;
                end else begin
                    ca[9:1]  = col;
                    ca[10]   = ~ap;
                end
            end
            MRW: begin
                if (!ui_sel) begin
                    ca[4:0]  = CA_OP_MRW;
                    ca[12:5] = ma;
                end else begin
                    ca[7:0]  = op;
                    ca[10]   = cw;
                end
            end
            default: ca = '0;
        endcase
    end

endmodule

// File: rtl/ddr5_dfi_command_encoder.sv
// ----------------------------------------------------------------------------
// ddr5_dfi_command_encoder
//   Accepts one WRITE or MRW per valid/ready handshake and serialises it onto
//   the DFI CA bus as UI0 (chip select low) followed by UI1 (deselected CS),
//   then holds at least pCMD_GAP deselect cycles before the next UI0.
//   Ports:
//     clk_i, rst_i          clock, asynchronous active-low reset
//     enable_i              gates new accepts; in-flight commands complete
//     cmd_valid_i/ready_o   command handshake (ready is combinational)
//     cmd_type_i/rank_i     command type and target rank
//     wr_*_i                WRITE payload
//     mr_*_i                MRW payload
//     dfi_address_o         registered 14-bit CA bus
//     dfi_cs_o              registered active-low chip selects
//     busy_o                high in CMD or GAP
//     err_o                 one-cycle pulse after an illegal accept
// ----------------------------------------------------------------------------
module ddr5_dfi_command_encoder
    import ddr5_phy_pkg::*;
#(
    parameter int pNUM_RANK = 1,
    parameter int pRANK_W   = 1,
    parameter int pCMD_GAP  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_type_i,
    input  logic [pRANK_W-1:0]   cmd_rank_i,
    input  logic [1:0]           wr_bank_i,
    input  logic [2:0]           wr_bg_i,
    input  logic [8:0]           wr_col_i,
    input  logic                 wr_ap_i,
    input  logic                 wr_bl_alt_i,
    input  logic [7:0]           mr_addr_i,
    input  logic [7:0]           mr_op_i,
    input  logic                 mr_cw_i,
    output logic [13:0]          dfi_address_o,
    output logic [pNUM_RANK-1:0] dfi_cs_o,
    output logic                 busy_o,
    output logic                 err_o
);

    enc_state_e           state;
    logic [2:0]           gap_cnt;
    cmd_fields_t          cap;
    cmd_fields_t          live;
    cmd_fields_t          sel;
    logic                 accept;
    logic                 legal;
    logic [CA_W-1:0]      ca_word;
    logic [pNUM_RANK-1:0] cs_ui0;

    always_comb begin
        live        = '0;
        live.typ    = cmd_type_e'(cmd_type_i);
        live.bank   = wr_bank_i;
        live.bg     = wr_bg_i;
        live.col    = wr_col_i;
        live.ap     = wr_ap_i;
        live.bl_alt = wr_bl_alt_i;
        live.ma     = mr_addr_i;
        live.op     = mr_op_i;
        live.cw     = mr_cw_i;
    end

    always_comb begin
        cmd_ready_o = 1'b0;
        if (enable_i) begin
            case (state)
                IDLE:    cmd_ready_o = 1'b1;
                UI1:     cmd_ready_o = (pCMD_GAP == 0);
                GAP:     cmd_ready_o = (gap_cnt == 3'd1);
                default: cmd_ready_o = 1'b0;
            endcase
        end
    end

    assign accept = cmd_valid_i && cmd_ready_o;
    assign legal  = is_legal_type(cmd_type_e'(cmd_type_i)) &&
                    (32'(cmd_rank_i) < 32'(pNUM_RANK));

    always_comb begin
        cs_ui0 = '1;
        for (int unsigned i = 0; i < pNUM_RANK; i++) begin
            cs_ui0[i] = (i != 32'(cmd_rank_i));
        end
    end

    // One packer serves both UIs: on an accept it encodes UI0 straight from
    // the inputs (the capture register is not loaded yet); otherwise it
    // encodes UI1 from the captured payload.
    assign sel = accept ? live : cap;

    ddr5_ca_pack u_ca_pack (
        .cmd_type (sel.typ),
        .bank     (sel.bank),
        .bg       (sel.bg),
        .col      (sel.col),
        .ap       (sel.ap),
        .bl_alt   (sel.bl_alt),
        .ma       (sel.ma),
        .op       (sel.op),
        .cw       (sel.cw),
        .ui_sel   (!accept),
        .ca       (ca_word)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            cap           <= '0;
            dfi_address_o <= '0;
            dfi_cs_o      <= '1;
            err_o         <= 1'b0;
        end else begin
            err_o         <= accept && !legal;
            dfi_address_o <= '0;
            dfi_cs_o      <= '1;
            if (accept && legal) begin
                cap           <= live;
                state         <= CMD;
                gap_cnt       <= '0;
                dfi_address_o <= ca_word;
                dfi_cs_o      <= cs_ui0;
            end else begin
                // An illegal accept falls through here: the bus stays
                // deselected and UI1/GAP exit to IDLE as usual.
                case (state)
                    IDLE: state <= IDLE;
                    CMD: begin
                        state         <= UI1;
                        dfi_address_o <= ca_word;
                    end
                    UI1: begin
                        if (pCMD_GAP == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= 3'(pCMD_GAP);
                        end
                    end
                    GAP: begin
                        gap_cnt <= gap_cnt - 3'd1;
                        if (gap_cnt == 3'd1) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy_o = (state == CMD) || (state == GAP);

endmodule

// File: tb/tb_ddr5_dfi_command_encoder.sv
module tb_ddr5_dfi_command_encoder;
    import ddr5_phy_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        enable;
    logic        cmd_valid;
    logic        v0;
    logic [1:0]  cmd_type;
    logic [1:0]  rank;
    logic        rank0;
    logic [1:0]  bank;
    logic [2:0]  bg;
    logic [8:0]  col;
    logic        ap;
    logic        bl_alt;
    logic [7:0]  ma;
    logic [7:0]  op;
    logic        cw;

    logic        ready, busy, err;
    logic [13:0] addr;
    logic [1:0]  cs;
    logic        ready0, busy0, err0;
    logic [13:0] addr0;
    logic [0:0]  cs0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Two ranks, default gap of 2
    ddr5_dfi_command_encoder #(.pNUM_RANK(2), .pRANK_W(2), .pCMD_GAP(2)) dut (
        .clk_i(clk), .rst_i(rst_n), .enable_i(enable), .cmd_valid_i(cmd_valid),
        .cmd_ready_o(ready), .cmd_type_i(cmd_type), .cmd_rank_i(rank),
        .wr_bank_i(bank), .wr_bg_i(bg), .wr_col_i(col), .wr_ap_i(ap),
        .wr_bl_alt_i(bl_alt), .mr_addr_i(ma), .mr_op_i(op), .mr_cw_i(cw),
        .dfi_address_o(addr), .dfi_cs_o(cs), .busy_o(busy), .err_o(err)
    );

    // Single rank, zero gap
    ddr5_dfi_command_encoder #(.pNUM_RANK(1), .pRANK_W(1), .pCMD_GAP(0)) dut_g0 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(enable), .cmd_valid_i(v0),
        .cmd_ready_o(ready0), .cmd_type_i(cmd_type), .cmd_rank_i(rank0),
        .wr_bank_i(bank), .wr_bg_i(bg), .wr_col_i(col), .wr_ap_i(ap),
        .wr_bl_alt_i(bl_alt), .mr_addr_i(ma), .mr_op_i(op), .mr_cw_i(cw),
        .dfi_address_o(addr0), .dfi_cs_o(cs0), .busy_o(busy0), .err_o(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [13:0] exp_ca(input logic [1:0] t, input logic [1:0] bk,
                                           input logic [2:0] g, input logic [8:0] c,
                                           input logic a, input logic bl,
                                           input logic [7:0] m, input logic [7:0] o,
                                           input logic w, input bit u1);
        logic [13:0] v;
        v = '0;
        if (t == 2'b01 && !u1)      v = {3'b000, g, bk, ~bl, 5'b01101};
        else if (t == 2'b01)        v = {3'b000, ~a, c, 1'b0};
        else if (t == 2'b10 && !u1) v = {1'b0, m, 5'b00101};
        else if (t == 2'b10)        v = {3'b000, w, 2'b00, o};
        return v;
    endfunction

    typedef struct {
        logic [13:0] a0;
        logic [1:0]  cs0;
        logic [13:0] a1;
    } exp_t;

    exp_t sb[$];
    int   last_ui1 = 0;
    int   last_gap = -1;

    // Monitor for the two-rank encoder: every UI0 pops one expectation,
    // the following cycle must carry its UI1, anything else is deselect.
    initial begin : monitor
        exp_t e;
        bit   pending;
        pending = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 0;
            end else if (pending) begin
                chk("ui1_addr", 32'(addr), 32'(e.a1));
                chk("ui1_cs", 32'(cs), 32'h3);
                pending  = 0;
                last_ui1 = cyc;
            end else if (cs !== 2'b11) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ui0", 32'(cs), 32'h3);
                end else begin
                    e = sb.pop_front();
                    chk("ui0_addr", 32'(addr), 32'(e.a0));
                    chk("ui0_cs", 32'(cs), 32'(e.cs0));
                    pending  = 1;
                    last_gap = cyc - last_ui1 - 1;
                end
            end else begin
                chk("deselect_addr", 32'(addr), 32'h0);
            end
        end
    end

    task automatic send_cmd(input logic [1:0] t, input logic [1:0] r, input logic [1:0] bk,
                            input logic [2:0] g, input logic [8:0] c, input logic a,
                            input logic bl, input logic [7:0] m, input logic [7:0] o,
                            input logic w);
        int unsigned n;
        exp_t e;
        n = 0;
        @(negedge clk);
        cmd_type = t; rank = r; bank = bk; bg = g; col = c; ap = a; bl_alt = bl;
        ma = m; op = o; cw = w; cmd_valid = 1'b1;
        #1;
        while (!ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ready) begin
            chk("ready_timeout", 32'h0, 32'h1);
            cmd_valid = 1'b0;
            return;
        end
        if ((t == 2'b01 || t == 2'b10) && r < 2'd2) begin
            e.a0  = exp_ca(t, bk, g, c, a, bl, m, o, w, 1'b0);
            e.cs0 = (r == 2'd0) ? 2'b10 : 2'b01;
            e.a1  = exp_ca(t, bk, g, c, a, bl, m, o, w, 1'b1);
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [1:0] t;
        logic [1:0] r;
        rst_n = 1'b0; enable = 1'b1; cmd_valid = 1'b0; v0 = 1'b0;
        cmd_type = '0; rank = '0; rank0 = 1'b0; bank = '0; bg = '0; col = '0;
        ap = 1'b0; bl_alt = 1'b0; ma = '0; op = '0; cw = 1'b0;

        // Reset values
        wait_cyc(2);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_cs", 32'(cs), 32'h3);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        #2 rst_n = 1'b1;
        #1 chk("ready_after_rst", 32'(ready), 32'h1);

        // WRITE rank 0, col 0x00E, ap 0, bl_alt 1
        send_cmd(2'b01, 2'd0, 2'd0, 3'd0, 9'h00E, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_cmd", 32'(busy), 32'h1);
        wait_cyc(6);
        chk("busy_idle", 32'(busy), 32'h0);

        // MRW MA 0x08 OP 0x98 to rank 1
        send_cmd(2'b10, 2'd1, 2'd0, 3'd0, 9'h000, 1'b0, 1'b0, MR_PREPOST, 8'h98, 1'b0);
        drop();
        wait_cyc(6);

        // Back-to-back MRWs with valid held high
        send_cmd(2'b10, 2'd0, 2'd0, 3'd0, 9'h000, 1'b0, 1'b0, MR_CRC, 8'h06, 1'b0);
        send_cmd(2'b10, 2'd0, 2'd0, 3'd0, 9'h000, 1'b0, 1'b0, MR_BL, 8'h03, 1'b0);
        drop();
        wait_cyc(6);
        chk("b2b_gap", 32'(last_gap), 32'd2);

        // Illegal type 11
        send_cmd(2'b11, 2'd0, 2'd1, 3'd2, 9'h1FF, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("err_pulse", 32'(err), 32'h1);
        chk("err_cs", 32'(cs), 32'h3);
        chk("err_addr", 32'(addr), 32'h0);
        chk("err_busy", 32'(busy), 32'h0);
        @(negedge clk);
        chk("err_one_cycle", 32'(err), 32'h0);

        // Illegal rank
        send_cmd(2'b01, 2'd2, 2'd3, 3'd7, 9'h155, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("err_rank", 32'(err), 32'h1);
        @(negedge clk);
        chk("err_rank_one_cycle", 32'(err), 32'h0);

        // Illegal type 00
        send_cmd(2'b00, 2'd0, 2'd0, 3'd0, 9'h000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("err_nop", 32'(err), 32'h1);
        wait_cyc(2);

        // enable_i dropped during CMD: UI1 still issued, no new accept
        send_cmd(2'b01, 2'd1, 2'd2, 3'd5, 9'h0A3, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        #1 chk("ready_en_low_cmd", 32'(ready), 32'h0);
        repeat (6) begin
            @(negedge clk);
            #1 chk("ready_en_low", 32'(ready), 32'h0);
        end
        cmd_valid = 1'b0;
        enable = 1'b1;
        #1 chk("ready_en_back", 32'(ready), 32'h1);

        // Reset during CMD aborts the sequence
        send_cmd(2'b10, 2'd0, 2'd0, 3'd0, 9'h000, 1'b0, 1'b0, 8'h08, 8'h98, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_cs", 32'(cs), 32'h3);
        chk("rst_mid_addr", 32'(addr), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("rst_mid_ready", 32'(ready), 32'h1);
        repeat (4) begin
            @(negedge clk);
            #1 chk("no_residual_ui1", 32'(addr), 32'h0);
        end

        // Random legal traffic, mixed back-to-back and idle gaps
        for (int i = 0; i < 24; i++) begin
            t = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            r = 2'($urandom_range(0, 1));
            send_cmd(t, r, 2'($urandom), 3'($urandom), 9'($urandom), 1'($urandom),
                     1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) != 0) begin
                drop();
                wait_cyc($urandom_range(0, 3));
            end
        end
        drop();
        wait_cyc(8);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        // Zero-gap instance: second UI0 directly follows first UI1
        @(negedge clk);
        cmd_type = 2'b10; ma = 8'h32; op = 8'h06; cw = 1'b0; rank0 = 1'b0; v0 = 1'b1;
        #1 chk("g0_ready_idle", 32'(ready0), 32'h1);
        @(negedge clk);
        chk("g0_ui0a_cs", 32'(cs0), 32'h0);
        chk("g0_ui0a", 32'(addr0), 32'h0645);
        ma = 8'h00; op = 8'h03;
        #1 chk("g0_ready_cmd", 32'(ready0), 32'h0);
        @(negedge clk);
        chk("g0_ui1a_cs", 32'(cs0), 32'h1);
        chk("g0_ui1a", 32'(addr0), 32'h0006);
        chk("g0_ready_ui1", 32'(ready0), 32'h1);
        @(negedge clk);
        v0 = 1'b0;
        chk("g0_ui0b_cs", 32'(cs0), 32'h0);
        chk("g0_ui0b", 32'(addr0), 32'h0005);
        @(negedge clk);
        chk("g0_ui1b_cs", 32'(cs0), 32'h1);
        chk("g0_ui1b", 32'(addr0), 32'h0003);
        @(negedge clk);
        chk("g0_desel_cs", 32'(cs0), 32'h1);
        chk("g0_desel_addr", 32'(addr0), 32'h0);
        chk("g0_err", 32'(err0), 32'h0);
        chk("g0_busy", 32'(busy0), 32'h0);

        wait_cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
